// File: rtl/sm_muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: FSM encoding, oper codes
// and the CPU funct codes that the decoder maps onto them.
package sm_muldiv_pkg;

    typedef enum logic [1:0] {
        MDS_IDLE = 2'd0,
        MDS_RUN  = 2'd1,
        MDS_FIX  = 2'd2,
        MDS_DONE = 2'd3
    } mdState_e;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    function automatic logic isMulDiv(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/sm_muldiv_step.sv
// One radix-2 iteration: LSB-first shift-add for multiply, or a restoring
// subtract step for divide. acc holds the upper half / partial remainder.
module sm_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             isDiv,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mq,
    input  logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] accNext,
    output logic [WIDTH-1:0] mqNext
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] diff_s;

    // Since acc < opB always holds, the top bit of diff is the borrow.
    always_comb begin
        sum_s     = {1'b0, acc} + {1'b0, opB};
        shifted_s = {acc, mq[WIDTH-1]};
        diff_s    = shifted_s - {1'b0, opB};
        if (isDiv) begin
            if (diff_s[WIDTH]) begin
                accNext = shifted_s[WIDTH-1:0];
            end else begin
                accNext = diff_s[WIDTH-1:0];
            end
            mqNext = {mq[WIDTH-2:0], ~diff_s[WIDTH]};
        end else if (mq[0]) begin
            accNext = sum_s[WIDTH:1];
            mqNext  = {sum_s[0], mq[WIDTH-1:1]};
        end else begin
            accNext = {1'b0, acc[WIDTH-1:1]};
            mqNext  = {acc[0], mq[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/sm_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// The first RUN cycle converts latched operands to magnitudes; FIX restores signs.
module sm_muldiv
    import sm_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       oper,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             divZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    mdState_e         state_r, stateNext_s;
    logic [CW-1:0]    cnt_r;
    logic             prep_r;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] rawA_r, rawB_r, acc_r, mq_r, opB_r, hi_r, lo_r;
    logic             divZero_r;

    logic             busy_s, accept_s, moveHi_s, moveLo_s, lastStep_s;
    logic             isDiv_s, signA_s, signB_s;
    logic [WIDTH-1:0] magA_s, magB_s, accNext_s, mqNext_s, hiRes_s, loRes_s;
    logic [2*WIDTH-1:0] prod_s;

    assign busy_s     = (state_r == MDS_RUN) || (state_r == MDS_FIX);
    assign accept_s   = start && !flush && !busy_s && isMulDiv(oper);
    assign moveHi_s   = start && !flush && !busy_s && (oper == MD_MTHI);
    assign moveLo_s   = start && !flush && !busy_s && (oper == MD_MTLO);
    assign lastStep_s = !prep_r && (cnt_r == CW'(WIDTH - 1));

    assign isDiv_s = op_r[1];
    assign signA_s = !op_r[0] && rawA_r[WIDTH-1];
    assign signB_s = !op_r[0] && rawB_r[WIDTH-1];
    assign magA_s  = signA_s ? ({WIDTH{1'b0}} - rawA_r) : rawA_r;
    assign magB_s  = signB_s ? ({WIDTH{1'b0}} - rawB_r) : rawB_r;
    assign prod_s  = {acc_r, mq_r};

    sm_muldiv_step #(.WIDTH(WIDTH)) uStep (
        .isDiv   (isDiv_s),
        .acc     (acc_r),
        .mq      (mq_r),
        .opB     (opB_r),
        .accNext (accNext_s),
        .mqNext  (mqNext_s)
    );

    // Next-state logic; flush pulls RUN/FIX straight back to IDLE.
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            MDS_IDLE: stateNext_s = accept_s ? MDS_RUN : MDS_IDLE;
            MDS_RUN: begin
                if (flush)           stateNext_s = MDS_IDLE;
                else if (lastStep_s) stateNext_s = MDS_FIX;
                else                 stateNext_s = MDS_RUN;
            end
            MDS_FIX:  stateNext_s = flush ? MDS_IDLE : MDS_DONE;
            MDS_DONE: stateNext_s = accept_s ? MDS_RUN : MDS_IDLE;
            default:  stateNext_s = MDS_IDLE;
        endcase
    end

    // Sign correction of the magnitude result, plus the divide-by-zero override.
    always_comb begin
        hiRes_s = acc_r;
        loRes_s = mq_r;
        if (!isDiv_s) begin
            if (signA_s ^ signB_s) begin
                {hiRes_s, loRes_s} = {(2*WIDTH){1'b0}} - prod_s;
            end else begin
                {hiRes_s, loRes_s} = prod_s;
            end
        end else if (rawB_r == {WIDTH{1'b0}}) begin
            hiRes_s = rawA_r;
            loRes_s = {WIDTH{1'b1}};
        end else begin
            loRes_s = (signA_s ^ signB_s) ? ({WIDTH{1'b0}} - mq_r) : mq_r;
            hiRes_s = signA_s ? ({WIDTH{1'b0}} - acc_r) : acc_r;
        end
    end

    // State, operand latches, iteration datapath and HI/LO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= MDS_IDLE;
            cnt_r     <= {CW{1'b0}};
            prep_r    <= 1'b0;
            op_r      <= 2'b00;
            rawA_r    <= {WIDTH{1'b0}};
            rawB_r    <= {WIDTH{1'b0}};
            acc_r     <= {WIDTH{1'b0}};
            mq_r      <= {WIDTH{1'b0}};
            opB_r     <= {WIDTH{1'b0}};
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            divZero_r <= 1'b0;
        end else begin
            state_r <= stateNext_s;
            if (accept_s) begin
                rawA_r    <= srcA;
                rawB_r    <= srcB;
                op_r      <= oper[1:0];
                prep_r    <= 1'b1;
                cnt_r     <= {CW{1'b0}};
                divZero_r <= 1'b0;
            end else if (state_r == MDS_RUN && !flush) begin
                if (prep_r) begin
                    prep_r <= 1'b0;
                    acc_r  <= {WIDTH{1'b0}};
                    mq_r   <= isDiv_s ? magA_s : magB_s;
                    opB_r  <= isDiv_s ? magB_s : magA_s;
                end else begin
                    acc_r <= accNext_s;
                    mq_r  <= mqNext_s;
                    cnt_r <= cnt_r + 1'b1;
                end
            end
            if (state_r == MDS_FIX && !flush) begin
                hi_r      <= hiRes_s;
                lo_r      <= loRes_s;
                divZero_r <= isDiv_s && (rawB_r == {WIDTH{1'b0}});
            end else if (moveHi_s) begin
                hi_r <= srcA;
            end else if (moveLo_s) begin
                lo_r <= srcA;
            end
        end
    end

    assign busy    = busy_s;
    assign done    = (state_r == MDS_DONE);
    assign divZero = divZero_r;
    assign hi      = hi_r;
    assign lo      = lo_r;

endmodule

// File: tb/tb_sm_muldiv.sv
// Directed bench for sm_muldiv (WIDTH=32): results, latency, MTHI/MTLO,
// flush, back-to-back issue and mid-operation reset.
module tb_sm_muldiv;

    logic        clk = 1'b0;
    logic        rst_n, start, flush;
    logic [2:0]  oper;
    logic [31:0] srcA, srcB;
    logic        busy, done, divZero;
    logic [31:0] hi, lo;

    int nChecks = 0;
    int nFail   = 0;
    int cyc     = 0;
    int nDone   = 0;

    sm_muldiv #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .oper    (oper),
        .srcA    (srcA),
        .srcB    (srcB),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .divZero (divZero),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic startOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        oper  = op;
        srcA  = a;
        srcB  = b;
        tick();
        start = 1'b0;
        srcA  = 32'hA5A5_A5A5;
        srcB  = 32'h5A5A_5A5A;
        cyc   = 0;
    endtask

    task automatic waitDone(input string tag);
        while (!done && cyc < 100) tick();
        check({tag, " latency"}, 64'(cyc), 64'd34);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        oper  = 3'b000;
        srcA  = 32'h0;
        srcB  = 32'h0;
        tick();
        tick();
        check("reset hi", 64'(hi), 64'h0);
        check("reset lo", 64'(lo), 64'h0);
        check("reset busy", 64'(busy), 64'h0);
        check("reset done", 64'(done), 64'h0);
        check("reset divZero", 64'(divZero), 64'h0);
        rst_n = 1'b1;
        tick();

        startOp(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu busy", 64'(busy), 64'h1);
        waitDone("multu max");
        check("multu max busy@done", 64'(busy), 64'h0);
        check("multu max hi", 64'(hi), 64'hFFFF_FFFE);
        check("multu max lo", 64'(lo), 64'h0000_0001);
        tick();
        check("done one cycle", 64'(done), 64'h0);

        startOp(3'b000, 32'hFFFF_FFFD, 32'd7);
        waitDone("mult -3*7");
        check("mult -3*7 hi", 64'(hi), 64'hFFFF_FFFF);
        check("mult -3*7 lo", 64'(lo), 64'hFFFF_FFEB);
        tick();

        startOp(3'b000, 32'h8000_0000, 32'h8000_0000);
        waitDone("mult minneg^2");
        check("mult minneg^2 hi", 64'(hi), 64'h4000_0000);
        check("mult minneg^2 lo", 64'(lo), 64'h0);
        tick();

        startOp(3'b010, 32'hFFFF_FFF9, 32'd2);
        waitDone("div -7/2");
        check("div -7/2 lo", 64'(lo), 64'hFFFF_FFFD);
        check("div -7/2 hi", 64'(hi), 64'hFFFF_FFFF);
        tick();

        startOp(3'b011, 32'd100, 32'd7);
        waitDone("divu 100/7");
        check("divu 100/7 lo", 64'(lo), 64'd14);
        check("divu 100/7 hi", 64'(hi), 64'd2);
        tick();

        startOp(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        waitDone("div minneg/-1");
        check("div minneg/-1 lo", 64'(lo), 64'h8000_0000);
        check("div minneg/-1 hi", 64'(hi), 64'h0);
        tick();

        startOp(3'b011, 32'd5, 32'd0);
        waitDone("divu 5/0");
        check("divu 5/0 lo", 64'(lo), 64'hFFFF_FFFF);
        check("divu 5/0 hi", 64'(hi), 64'd5);
        check("divu 5/0 divZero", 64'(divZero), 64'h1);
        tick();
        check("divZero held", 64'(divZero), 64'h1);

        startOp(3'b001, 32'd2, 32'd3);
        check("divZero cleared", 64'(divZero), 64'h0);
        waitDone("multu 2*3");
        check("multu 2*3 hi", 64'(hi), 64'h0);
        check("multu 2*3 lo", 64'(lo), 64'd6);
        tick();

        start = 1'b1; oper = 3'b100; srcA = 32'h1234;
        tick();
        check("mthi hi", 64'(hi), 64'h1234);
        check("mthi busy", 64'(busy), 64'h0);
        check("mthi done", 64'(done), 64'h0);
        oper = 3'b101; srcA = 32'h5678;
        tick();
        start = 1'b0;
        check("mtlo lo", 64'(lo), 64'h5678);
        check("mtlo hi kept", 64'(hi), 64'h1234);
        check("mtlo done", 64'(done), 64'h0);

        startOp(3'b001, 32'd2, 32'd2);
        while (cyc < 9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'h0);
        check("flush hi", 64'(hi), 64'h1234);
        check("flush lo", 64'(lo), 64'h5678);
        nDone = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) nDone++;
        end
        check("flush no done", 64'(nDone), 64'h0);

        startOp(3'b001, 32'd3, 32'd5);
        waitDone("b2b first");
        check("b2b first lo", 64'(lo), 64'd15);
        check("b2b first hi", 64'(hi), 64'h0);
        startOp(3'b011, 32'd100, 32'd7);
        while (cyc < 4) tick();
        start = 1'b1; oper = 3'b100; srcA = 32'hDEAD_BEEF;
        tick();
        oper = 3'b001; srcA = 32'd9; srcB = 32'd9;
        tick();
        start = 1'b0;
        check("mthi while busy", 64'(hi), 64'h0);
        check("busy after ignored start", 64'(busy), 64'h1);
        waitDone("b2b second");
        check("b2b second lo", 64'(lo), 64'd14);
        check("b2b second hi", 64'(hi), 64'd2);
        tick();

        startOp(3'b001, 32'd7, 32'd7);
        while (cyc < 10) tick();
        rst_n = 1'b0;
        tick();
        check("midrun reset hi", 64'(hi), 64'h0);
        check("midrun reset lo", 64'(lo), 64'h0);
        check("midrun reset busy", 64'(busy), 64'h0);
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
